// File: rtl/bcd_updown_counter_if.sv
// Control and count bus between the BCD counter and its neighbours.
// The master drives the controls; the slave (the counter) returns the count and pulses.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tc;
    logic                  load_err;
    logic                  changed;

    modport master (
        output en, up, load, load_val,
        input  bcd, tc, load_err, changed
    );

    modport slave (
        input  en, up, load, load_val,
        output bcd, tc, load_err, changed
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with validated parallel load.
// Every nibble of the output stays in 0-9 for the downstream BCD-to-Gray converters.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bcd_updown_counter_if.slave        bus
);
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_tc;
    logic                r_load_err;
    logic                r_changed;

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic                w_carry;
    logic                w_borrow;
    logic                w_load_ok;
    logic [3:0]          w_digit;

    // Ripple carry/borrow across all digits in one cycle; a chain that survives
    // past the top digit means the count wrapped.
    always_comb begin
        w_inc     = r_bcd;
        w_dec     = r_bcd;
        w_carry   = 1'b1;
        w_borrow  = 1'b1;
        w_load_ok = 1'b1;
        w_digit   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_bcd[4*i +: 4];
            if (w_carry) begin
                if (w_digit == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = w_digit + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (w_digit == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = w_digit - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcd      <= '0;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
            r_changed  <= 1'b0;
        end else begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
            r_changed  <= 1'b0;
            if (bus.load) begin
                if (w_load_ok) begin
                    r_bcd     <= bus.load_val;
                    r_changed <= 1'b1;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (bus.en) begin
                r_bcd     <= bus.up ? w_inc : w_dec;
                r_tc      <= bus.up ? w_carry : w_borrow;
                r_changed <= 1'b1;
            end
        end
    end

    assign bus.bcd      = r_bcd;
    assign bus.tc       = r_tc;
    assign bus.load_err = r_load_err;
    assign bus.changed  = r_changed;
endmodule
